spell_trace_tracker: RTL and testbench
======================================

# spell_trace_tracker

Upstream of the VGA display controller: turns the four raw wand-direction buttons into a cursor on the 4x4 spell-trace grid. It accumulates the set of visited cells into the 16-bit trace mask that the display's grid renderer consumes on `ir_in`. It also judges the trace against a target spell pattern, with a timeout.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised cycles before a button level is accepted (10 ms at 25 MHz); legal range 1..2^20-1.
- TIMEOUT_CYCLES, 250000000: maximum TRACE duration in clocks (10 s); counter 28 bits.
- iVGA_CLK  in  1  pixel clock; all logic on rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw, asynchronous, active-high, bouncy.
- start  in  1  one-cycle pulse; begins or restarts a trace.
- start_cell  in  4  cell where the trace begins; sampled with start.
- target_mask  in  16  spell pattern; sampled with start.
- cell_mask  out  16  visited cells, bit n = cell n; drives the display's `ir_in`.
- cursor_cell  out  4  current cell, index = row*4+col; row 0 top, col 0 left.
- busy  out  1  high in TRACE.
- success  out  1  high in DONE_OK.
- fail  out  1  high in DONE_FAIL.

## Operation
- Per-button path:
  - 2-FF synchroniser.
  - Debounce counter, cleared whenever the synchronised level equals the debounced level.
  - When the levels differ for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
  - press pulse = debounced & ~debounced_q (one cycle, rising only).
- Move arbitration: at most one move per cycle. Priority up > down > left > right; lower-priority pulses in the same cycle are dropped.
- Move rule: up = cell-4, down = cell+4, left = cell-1, right = cell+1.
  - A move off the grid edge is ignored: no cursor change, no mask change, no fail (e.g. left at col 0, up at row 0).
- FSM states: IDLE, TRACE, DONE_OK, DONE_FAIL.
  - IDLE: outputs at reset values. start -> TRACE.
  - Any state + start -> TRACE. Loads cursor_cell=start_cell, cell_mask=1<<start_cell, latches target_mask, clears the timeout counter; any press in the same cycle is ignored.
  - TRACE: on an accepted move, cursor moves and the new cell's bit is set (revisiting a set cell is legal, mask unchanged).
  - TRACE -> DONE_FAIL: the new cell is not in the latched target (its bit is still set in cell_mask), or the timeout counter reaches TIMEOUT_CYCLES-1.
  - TRACE -> DONE_OK: the next-state cell_mask equals the latched target. Start-cell-only targets complete on the cycle after start.
  - Stray cell and target completion cannot coincide; if timeout and a completing move coincide, DONE_OK wins.
  - DONE_OK, DONE_FAIL: hold cell_mask and cursor_cell; ignore buttons; leave only on start.
- start_cell not in target_mask: TRACE is entered normally; the first legal move evaluates normally.
- Debouncers run in every state, so a button held across start does not re-pulse.

## Timing
- Reset (async assert, sync-safe deassert): cell_mask=0, cursor_cell=0, busy=0, success=0, fail=0, state IDLE, debounced levels 0, all counters 0.
- Raw button rise at edge k, held clean: press pulse high during cycle k+2+DEBOUNCE_CYCLES; cursor_cell/cell_mask updated at edge k+3+DEBOUNCE_CYCLES.
- Glitch (any level change) shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- start at edge s: busy=1 and cell_mask=1<<start_cell visible after edge s.
- Status flags (busy/success/fail) change on the same edge as the causing cell_mask update; exactly one of busy/success/fail is high outside IDLE.
- Timeout: with no completing move, fail rises at edge s+TIMEOUT_CYCLES.
- All outputs registered; no combinational input-to-output paths.

## Test plan
Run with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=1000.
- Reset mid-TRACE (cell_mask=0x0003) -> all outputs 0 immediately, IDLE; no pulse from buttons held through reset until released and re-pressed.
- start, start_cell=0, target=0x000F; three clean right presses -> cell_mask 0x0003, 0x0007, 0x000F; success=1, busy=0 on the third update, each update exactly 7 edges after its raw rise.
- Bounce: right toggled high for 3 cycles, low for 1, repeated 5 times, then low -> no move; then held 4+ cycles -> one move.
- Clamp and priority:
  - cursor at 3, press right -> unchanged, still busy.
  - up+left pulses in the same cycle at cell 5 -> cursor 1 only.
- Stray: target 0x000F, start_cell 0, press down -> cursor 4, cell_mask 0x0011, fail=1; later presses ignored; new start -> busy=1, cell_mask=1<<start_cell.
- Timeout: start, no presses -> fail rises exactly 1000 edges after start; a completing move on the timeout edge instead yields success.

Source files
------------

// File: rtl/spell_trace_tracker_if.sv
// Control/status bundle between the spell-trace tracker and its host:
// trace start request in, cursor/trace mask and judgement flags out.
interface spell_trace_tracker_if;
  logic        start;
  logic [3:0]  start_cell;
  logic [15:0] target_mask;
  logic [15:0] cell_mask;
  logic [3:0]  cursor_cell;
  logic        busy;
  logic        success;
  logic        fail;

  modport master (
    output start, start_cell, target_mask,
    input  cell_mask, cursor_cell, busy, success, fail
  );

  modport slave (
    input  start, start_cell, target_mask,
    output cell_mask, cursor_cell, busy, success, fail
  );
endinterface

// File: rtl/spell_trace_tracker.sv
// Debounces the four wand buttons, walks a cursor over the 4x4 spell grid,
// accumulates the visited-cell mask and judges it against a target spell.
module spell_trace_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  spell_trace_tracker_if.slave bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_TRACE     = 2'd1;
  localparam logic [1:0] S_DONE_OK   = 2'd2;
  localparam logic [1:0] S_DONE_FAIL = 2'd3;

  localparam logic [19:0] DEB_LAST     = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT_CYCLES - 1);

  // Button index order: 0 up, 1 down, 2 left, 3 right (also the priority order).
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2, deb, deb_q, press;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [19:0] cnt;
    logic        lvl;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end

    assign deb[i] = lvl;
  end

  assign press = deb & ~deb_q;

  logic [1:0]  state;
  logic [3:0]  cursor;
  logic [15:0] cell_mask;
  logic [15:0] target;
  logic [27:0] timer;

  logic        move_valid;
  logic [3:0]  move_cell;
  logic [15:0] next_mask;
  logic [1:0]  row, col;

  assign row = cursor[3:2];
  assign col = cursor[1:0];

  // Only the highest-priority press is considered; if it would leave the grid
  // the whole cycle is a no-op rather than falling through to a lower button.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    move_valid = 1'b0;
    move_cell  = cursor;
    if (press[0]) begin
      if (row != 2'd0) begin
        move_valid = 1'b1;
        move_cell  = cursor - 4'd4;
      end
    end else if (press[1]) begin
      if (row != 2'd3) begin
        move_valid = 1'b1;
        move_cell  = cursor + 4'd4;
      end
    end else if (press[2]) begin
      if (col != 2'd0) begin
        move_valid = 1'b1;
        move_cell  = cursor - 4'd1;
      end
    end else if (press[3]) begin
      if (col != 2'd3) begin
        move_valid = 1'b1;
        move_cell  = cursor + 4'd1;
      end
    end
  end

  assign next_mask = move_valid ? (cell_mask | (16'(1) << move_cell)) : cell_mask;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= S_IDLE;
      cursor    <= '0;
      cell_mask <= '0;
      target    <= '0;
      timer     <= '0;
    end else if (bus.start) begin
      state     <= S_TRACE;
      cursor    <= bus.start_cell;
      cell_mask <= 16'(1) << bus.start_cell;
      target    <= bus.target_mask;
      timer     <= '0;
    end else if (state == S_TRACE) begin
      timer <= timer + 28'd1;
      if (move_valid) begin
        cursor    <= move_cell;
        cell_mask <= next_mask;
      end
      // A stray cell can never complete the target, and completion beats timeout.
      if (move_valid && !target[move_cell]) begin
        state <= S_DONE_FAIL;
      end else if (next_mask == target) begin
        state <= S_DONE_OK;
      end else if (timer == TIMEOUT_LAST) begin
        state <= S_DONE_FAIL;
      end
    end
  end

  assign bus.cell_mask   = cell_mask;
  assign bus.cursor_cell = cursor;
  assign bus.busy        = (state == S_TRACE);
  assign bus.success     = (state == S_DONE_OK);
  assign bus.fail        = (state == S_DONE_FAIL);

endmodule

// File: tb/tb_spell_trace_tracker.sv
// Directed bench for spell_trace_tracker with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000.
module tb_spell_trace_tracker;

  localparam int DEB = 4;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;

  int checks   = 0;
  int failures = 0;

  spell_trace_tracker_if trk ();

  spell_trace_tracker #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .bus      (trk.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_up    = v;
      1:       btn_down  = v;
      2:       btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic check_out(input string tag, input logic [15:0] m, input logic [3:0] c,
                           input logic b, input logic s, input logic f);
    check($sformatf("%s.mask", tag), 32'(trk.cell_mask), 32'(m));
    check($sformatf("%s.cursor", tag), 32'(trk.cursor_cell), 32'(c));
    check($sformatf("%s.busy", tag), 32'(trk.busy), 32'(b));
    check($sformatf("%s.success", tag), 32'(trk.success), 32'(s));
    check($sformatf("%s.fail", tag), 32'(trk.fail), 32'(f));
  endtask

  task automatic do_start(input logic [3:0] c, input logic [15:0] t);
    trk.start       = 1'b1;
    trk.start_cell  = c;
    trk.target_mask = t;
    tick(1);
    trk.start = 1'b0;
  endtask

  // Clean press: raw rise right after edge k, mask must still be old after
  // edge k+6 and updated after edge k+7. Button is released, not yet settled.
  task automatic press(input string tag, input int b, input logic [15:0] m_before,
                       input logic [15:0] m_after, input logic [3:0] c_after);
    set_btn(b, 1'b1);
    tick(6);
    check($sformatf("%s.early", tag), 32'(trk.cell_mask), 32'(m_before));
    tick(1);
    check($sformatf("%s.mask", tag), 32'(trk.cell_mask), 32'(m_after));
    check($sformatf("%s.cursor", tag), 32'(trk.cursor_cell), 32'(c_after));
    set_btn(b, 1'b0);
  endtask

  initial begin
    trk.start       = 1'b0;
    trk.start_cell  = '0;
    trk.target_mask = '0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_out("por", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_out("idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // Three clean right presses complete target 0x000F
    do_start(4'd0, 16'h000F);
    check_out("a.start", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    press("a.r1", 3, 16'h0001, 16'h0003, 4'd1);
    tick(8);
    press("a.r2", 3, 16'h0003, 16'h0007, 4'd2);
    check("a.r2.busy", 32'(trk.busy), 32'd1);
    tick(8);
    press("a.r3", 3, 16'h0007, 16'h000F, 4'd3);
    check_out("a.done", 16'h000F, 4'd3, 1'b0, 1'b1, 1'b0);
    tick(8);

    // Bounce rejection, then clamp at column 3, then priority at cell 5
    do_start(4'd2, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      btn_right = 1'b1;
      tick(3);
      btn_right = 1'b0;
      tick(1);
    end
    tick(10);
    check_out("b.bounce", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b0);
    press("b.right", 3, 16'h0004, 16'h000C, 4'd3);
    tick(8);
    press("b.clamp", 3, 16'h000C, 16'h000C, 4'd3);
    check("b.clamp.busy", 32'(trk.busy), 32'd1);
    tick(8);
    press("b.down", 1, 16'h000C, 16'h008C, 4'd7);
    tick(8);
    press("b.left1", 2, 16'h008C, 16'h00CC, 4'd6);
    tick(8);
    press("b.left2", 2, 16'h00CC, 16'h00EC, 4'd5);
    tick(8);
    btn_up   = 1'b1;
    btn_left = 1'b1;
    tick(7);
    check_out("b.prio", 16'h00EE, 4'd1, 1'b1, 1'b0, 1'b0);
    btn_up   = 1'b0;
    btn_left = 1'b0;
    tick(8);
    check("b.prio.after", 32'(trk.cursor_cell), 32'd1);

    // Stray cell fails; later presses ignored; restart recovers
    do_start(4'd0, 16'h000F);
    press("c.down", 1, 16'h0001, 16'h0011, 4'd4);
    check_out("c.fail", 16'h0011, 4'd4, 1'b0, 1'b0, 1'b1);
    tick(8);
    press("c.ignored", 3, 16'h0011, 16'h0011, 4'd4);
    check("c.ignored.fail", 32'(trk.fail), 32'd1);
    tick(8);
    do_start(4'd6, 16'h000F);
    check_out("c.restart", 16'h0040, 4'd6, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-trace with a button held through it
    do_start(4'd0, 16'h000F);
    press("d.right", 3, 16'h0001, 16'h0003, 4'd1);
    tick(8);
    btn_up = 1'b1;
    tick(8);
    #2 rst_n = 1'b0;
    #1 check_out("d.rst", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_out("d.idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    do_start(4'd5, 16'hFFFF);
    tick(10);
    check_out("d.held", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b0);
    btn_up = 1'b0;
    tick(8);
    press("d.repress", 0, 16'h0020, 16'h0022, 4'd1);
    tick(8);

    // Start-cell-only target completes on the cycle after start
    do_start(4'd9, 16'h0200);
    check_out("e.start", 16'h0200, 4'd9, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("e.done", 16'h0200, 4'd9, 1'b0, 1'b1, 1'b0);

    // Timeout exactly TMO edges after start
    do_start(4'd0, 16'h000F);
    tick(TMO - 1);
    check_out("f.pre", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("f.timeout", 16'h0001, 4'd0, 1'b0, 1'b0, 1'b1);

    // Completing move landing on the timeout edge wins
    do_start(4'd0, 16'h0003);
    tick(TMO - 7);
    btn_right = 1'b1;
    tick(6);
    check_out("g.pre", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("g.win", 16'h0003, 4'd1, 1'b0, 1'b1, 1'b0);
    btn_right = 1'b0;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
